// File: rtl/lcd_text_formatter.sv
// Converts two 16-bit values into a 2x16 ASCII screen ("A=ddddd" / "B=ddddd") via sequential double-dabble.
// Optional leading-zero blanking of each 5-digit field: define LCDFMT_LZB_EN.
module lcd_text_formatter (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value_a,
  input  logic [15:0] value_b,
  input  logic        start,
  output logic [7:0]  ASCII [32],
  output logic        UpdateLCD,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, CONV_A, CONV_B, WRITE, NOTIFY} state_t;

  state_t      state_reg, state_next;
  logic        pending_reg;
  logic [15:0] shadow_a_reg, shadow_b_reg;
  logic [19:0] bcd_a_reg, bcd_b_reg;
  logic [3:0]  cnt_reg;
  logic        update_reg;
  logic [7:0]  ascii_reg [32];
  logic [19:0] adj_a, adj_b;
  logic [39:0] text_a, text_b;
  logic        restart;

  // Add-3 correction on every BCD nibble before each shift
  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_adj
      assign adj_a[gi*4 +: 4] = (bcd_a_reg[gi*4 +: 4] >= 4'd5) ? bcd_a_reg[gi*4 +: 4] + 4'd3
                                                                 : bcd_a_reg[gi*4 +: 4];
      assign adj_b[gi*4 +: 4] = (bcd_b_reg[gi*4 +: 4] >= 4'd5) ? bcd_b_reg[gi*4 +: 4] + 4'd3
                                                                 : bcd_b_reg[gi*4 +: 4];
    end
  endgenerate

  // Packs 5 characters, most significant digit in the top byte
  function automatic logic [39:0] fmt_field(input logic [19:0] bcd);
    logic [39:0] chars;
    logic [3:0]  digit;
`ifdef LCDFMT_LZB_EN
    logic        lead;
    lead = 1'b1;
`endif
    chars = '0;
    for (int i = 4; i >= 0; i--) begin
      digit = bcd[i*4 +: 4];
      chars[i*8 +: 8] = 8'h30 + {4'h0, digit};
`ifdef LCDFMT_LZB_EN
      if (lead && digit == 4'd0 && i != 0) chars[i*8 +: 8] = 8'h20;
      else lead = 1'b0;
`endif
    end
    return chars;
  endfunction

  assign text_a    = fmt_field(bcd_a_reg);
  assign text_b    = fmt_field(bcd_b_reg);
  assign restart   = pending_reg | start;
  assign busy      = (state_reg != IDLE);
  assign UpdateLCD = update_reg;
  assign ASCII     = ascii_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = CONV_A;
      CONV_A:  if (cnt_reg == 4'd15) state_next = CONV_B;
      CONV_B:  if (cnt_reg == 4'd15) state_next = WRITE;
      WRITE:   state_next = NOTIFY;
      NOTIFY:  state_next = restart ? CONV_A : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      pending_reg  <= 1'b0;
      shadow_a_reg <= '0;
      shadow_b_reg <= '0;
      bcd_a_reg    <= '0;
      bcd_b_reg    <= '0;
      cnt_reg      <= '0;
      update_reg   <= 1'b0;
      for (int i = 0; i < 32; i++) ascii_reg[i] <= 8'h20;
    end else begin
      state_reg  <= state_next;
      update_reg <= 1'b0;
      if (start && state_reg != IDLE && state_reg != NOTIFY) pending_reg <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (start) begin
            shadow_a_reg <= value_a;
            shadow_b_reg <= value_b;
            bcd_a_reg    <= '0;
            bcd_b_reg    <= '0;
            cnt_reg      <= '0;
          end
        end
        CONV_A: begin
          {bcd_a_reg, shadow_a_reg} <= {adj_a, shadow_a_reg} << 1;
          cnt_reg <= cnt_reg + 4'd1;
        end
        CONV_B: begin
          {bcd_b_reg, shadow_b_reg} <= {adj_b, shadow_b_reg} << 1;
          cnt_reg <= cnt_reg + 4'd1;
        end
        WRITE: begin
          for (int i = 0; i < 32; i++) ascii_reg[i] <= 8'h20;
          ascii_reg[0]  <= 8'h41;
          ascii_reg[1]  <= 8'h3D;
          ascii_reg[16] <= 8'h42;
          ascii_reg[17] <= 8'h3D;
          for (int j = 0; j < 5; j++) begin
            ascii_reg[2 + j]  <= text_a[(4 - j)*8 +: 8];
            ascii_reg[18 + j] <= text_b[(4 - j)*8 +: 8];
          end
          update_reg <= 1'b1;
        end
        NOTIFY: begin
          // A start seen on this edge is folded into the restart
          pending_reg <= 1'b0;
          if (restart) begin
            shadow_a_reg <= value_a;
            shadow_b_reg <= value_b;
            bcd_a_reg    <= '0;
            bcd_b_reg    <= '0;
            cnt_reg      <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_text_formatter.sv
// Scoreboard bench for lcd_text_formatter: stimulus pushes expected screens and pulse cycles, a monitor checks each UpdateLCD.
module tb_lcd_text_formatter;

`ifdef LCDFMT_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] value_a = '0;
  logic [15:0] value_b = '0;
  logic        start = 1'b0;
  logic [7:0]  ascii [32];
  logic        update;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {
    logic [255:0] img;
    int           at;
  } exp_t;
  exp_t exp_q[$];

  lcd_text_formatter dut (
    .clk      (clk),
    .reset    (reset),
    .value_a  (value_a),
    .value_b  (value_b),
    .start    (start),
    .ASCII    (ascii),
    .UpdateLCD(update),
    .busy     (busy)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [255:0] mk(input string l1, input string l2);
    logic [255:0] img;
    img = {32{8'h20}};
    for (int i = 0; i < l1.len(); i++) img[255 - 8*i -: 8] = l1[i];
    for (int i = 0; i < l2.len(); i++) img[255 - 8*(16 + i) -: 8] = l2[i];
    return img;
  endfunction

  function automatic logic [255:0] dut_img();
    logic [255:0] img;
    for (int i = 0; i < 32; i++) img[255 - 8*i -: 8] = ascii[i];
    return img;
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end else
      $display("ok   %s: %h", name, act);
  endtask

  task automatic expect_pulse(input logic [255:0] img, input int at);
    exp_t e;
    e.img = img;
    e.at  = at;
    exp_q.push_back(e);
  endtask

  // One-cycle start; the sampling edge is cyc+1, pulse visible at cyc+34
  task automatic pulse_start(input logic [15:0] a, input logic [15:0] b, input logic [255:0] img);
    value_a = a;
    value_b = b;
    start   = 1'b1;
    expect_pulse(img, cyc + 34);
    tick();
    start = 1'b0;
  endtask

  // Monitor: pops one expected screen per UpdateLCD, watches ASCII stability
  logic [255:0] prev_img;
  logic         prev_upd = 1'b0;
  initial prev_img = {32{8'h20}};
  always @(negedge clk) begin
    logic [255:0] cur;
    exp_t e;
    cur = dut_img();
    if (reset && cur !== prev_img) begin
      vectors++;
      if (!update) begin
        miscompares++;
        $display("FAIL ascii_stable: changed at cycle %0d with UpdateLCD=%b, required change only with UpdateLCD=1", cyc, update);
      end
    end
    prev_img = cur;
    if (update) begin
      vectors++;
      if (prev_upd) begin
        miscompares++;
        $display("FAIL upd_double: UpdateLCD high at cycles %0d and %0d, required single cycle", cyc - 1, cyc);
      end
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL upd_unexpected: pulse at cycle %0d, required none", cyc);
      end else begin
        e = exp_q.pop_front();
        vectors++;
        if (e.at != cyc) begin
          miscompares++;
          $display("FAIL upd_time: pulse at cycle %0d, required %0d", cyc, e.at);
        end
        chk("screen", cur, e.img);
      end
    end
    prev_upd = update;
  end

  int t0;
  initial begin
    tick(3);
    chk("rst_ascii", dut_img(), mk("", ""));
    chk("rst_upd", {255'b0, update}, 256'd0);
    chk("rst_busy", {255'b0, busy}, 256'd0);
    reset = 1'b1;
    tick(2);

    // Basic refresh
    pulse_start(16'd12345, 16'd0, mk("A=12345", LZB ? "B=    0" : "B=00000"));
    chk("busy_on", {255'b0, busy}, 256'd1);
    tick(40);
    chk("busy_off", {255'b0, busy}, 256'd0);

    // Boundary values
    pulse_start(16'd65535, 16'd9, mk("A=65535", LZB ? "B=    9" : "B=00009"));
    tick(40);

    // Pending restart: second image uses A as of the NOTIFY edge
    t0 = cyc;
    pulse_start(16'd1, 16'd0, mk(LZB ? "A=    1" : "A=00001", LZB ? "B=    0" : "B=00000"));
    expect_pulse(mk(LZB ? "A=    8" : "A=00008", LZB ? "B=    0" : "B=00000"), t0 + 68);
    tick(9);
    value_a = 16'd7;
    start   = 1'b1;
    tick();
    start = 1'b0;
    tick(10);
    value_a = 16'd8;
    tick(60);
    chk("busy_after_restart", {255'b0, busy}, 256'd0);

    // Reset mid-conversion aborts without a pulse
    value_a = 16'd555;
    value_b = 16'd555;
    start   = 1'b1;
    tick();
    start = 1'b0;
    tick(19);
    reset = 1'b0;
    #1;
    chk("abort_ascii", dut_img(), mk("", ""));
    chk("abort_upd", {255'b0, update}, 256'd0);
    chk("abort_busy", {255'b0, busy}, 256'd0);
    tick(2);
    reset = 1'b1;
    tick(40);
    pulse_start(16'd42, 16'd65535, mk(LZB ? "A=   42" : "A=00042", "B=65535"));
    tick(40);

    // Sustained start: four pulses 34 cycles apart
    t0 = cyc;
    value_a = 16'd300;
    value_b = 16'd7;
    start   = 1'b1;
    for (int j = 0; j < 4; j++)
      expect_pulse(mk(LZB ? "A=  300" : "A=00300", LZB ? "B=    7" : "B=00007"), t0 + 34 + 34*j);
    tick();
    chk("busy_sustained", {255'b0, busy}, 256'd1);
    tick(99);
    start = 1'b0;
    tick(60);
    chk("busy_end", {255'b0, busy}, 256'd0);

    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL missing_pulses: %0d expected pulses never seen, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
